spi_txn_arbiter: RTL

- Shares one SPI master between NUM_REQ requesters; each requester owns one slave chip-select index.
- Round-robin arbitration; drives the master's start/data_in and the slave-select index; captures the master's data_out on done and returns it to the winning requester.
- Sits between client logic and the existing SPI master/slave pair. One transaction at a time.

---
 rtl/spi_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/spi_txn_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 1023;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above rr_ptr,
// wrapping around to index 0.
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [idx_w(NUM_REQ)-1:0] rr_ptr,
    output logic [idx_w(NUM_REQ)-1:0] owner,
    output logic                      valid
);

    localparam int SEL_W = idx_w(NUM_REQ);

    logic [SEL_W-1:0] cand;

    always_comb begin
        owner = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = SEL_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                owner = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sharing of one SPI master between NUM_REQ requesters.
// Optional WAIT-state timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic                        spi_start,
    output logic [DATA_W-1:0]           spi_data_in,
    output logic [idx_w(NUM_REQ)-1:0]   spi_sel,
    input  logic                        spi_done,
    input  logic [DATA_W-1:0]           spi_data_out,
    output logic                        busy
);

    localparam int SEL_W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("spi_txn_arbiter: parameter out of range");
    end

    arb_state_t         state;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   arb_owner;
    logic               arb_valid;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [DATA_W-1:0]  req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign arb_onehot = NUM_REQ'(1) << arb_owner;
    assign sel_onehot = NUM_REQ'(1) << spi_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .owner  (arb_owner),
        .valid  (arb_valid)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // spi_sel doubles as the owner register: it is latched at grant and held to completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
            spi_sel     <= '0;
            busy        <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            rsp_err     <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        spi_sel     <= arb_owner;
                        spi_data_in <= req_word[arb_owner];
                        gnt         <= arb_onehot;
                        spi_start   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    gnt       <= '0;
                    spi_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                    state     <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        rsp_data  <= spi_data_out;
                        rsp_valid <= sel_onehot;
                        state     <= RESP;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    // Leave on the edge where the count would reach TIMEOUT.
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_valid <= sel_onehot;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    rr_ptr    <= (spi_sel == SEL_W'(NUM_REQ - 1)) ? '0 : spi_sel + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    rsp_err   <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
